tone_generator: RTL and testbench
=================================

// Module: tone_generator
// PURPOSE
// - Sink side of the sound request interface (playSound + freq[8:0] in Hz).
// - Turns each request into a timed square wave on the speaker pin.
// - A fractional phase accumulator produces the tone; no divider is used.
// - A duration timer ends the note. The sound-mode state gates output via enable.
// PARAMETERS
// - CLK_HZ   10_000_000  system clock frequency, Hz
// - NOTE_MS  100         note length after the last accepted request, ms
// - ACC_W    24          accumulator width; must hold CLK_HZ/2 + 511
// PORTS
// - clk         in   1  system clock
// - nRst        in   1  reset, asynchronous, active-low
// - enable      in   1  sound mode ON (1) / OFF (0)
// - playSound   in   1  request strobe or level, sampled every clk
// - freq        in   9  requested tone, Hz; 0 = no tone
// - speaker     out  1  square-wave drive, registered
// - busy        out  1  high while a note is playing
// BEHAVIOUR
// - Constants: HALF = CLK_HZ/2; NOTE_CYC = NOTE_MS*(CLK_HZ/1000).
// - Reset: state=IDLE, speaker=0, busy=0, acc=0, dur_cnt=0, f_lat=0.
// - States are IDLE and PLAY. busy = (state==PLAY), registered.
// - Accept condition: enable & playSound & (freq!=0). freq==0 requests are ignored.
// - IDLE, on accept:
//   - next clk: state=PLAY, f_lat=freq, acc=0, dur_cnt=0, speaker=0.
//   - Latency from request to busy is exactly 1 clk.
// - PLAY, each clk:
//   - If acc+f_lat >= HALF: acc <= acc+f_lat-HALF and speaker toggles.
//   - Else: acc <= acc+f_lat.
//   - Sums are computed at ACC_W+1 bits; no overflow is allowed.
//   - Toggles after k PLAY cycles = floor(k*f_lat/HALF).
//   - Mean output frequency is exactly f_lat Hz.
// - PLAY, accept (retrigger):
//   - dur_cnt <= 0 and f_lat <= freq.
//   - acc and speaker are NOT reset, so the wave stays phase-continuous.
//   - A held playSound therefore sustains the note.
// - PLAY exit: dur_cnt == NOTE_CYC-1 with no accept in the same clk.
//   - Next clk: IDLE, speaker=0, acc=0.
//   - A PLAY with no retrigger lasts exactly NOTE_CYC clks.
// - Retrigger and terminal count in the same clk: the retrigger wins.
// - enable low in any state:
//   - Next clk: IDLE, speaker=0, acc=0, dur_cnt=0.
//   - Requests are dropped, not queued.
// - Reset mid-note: all outputs return to reset values immediately (async).
// CONFIGURATION
// - TONE_VOLUME_EN defined:
//   - Adds port volume, in, 2 bits.
//   - A 2-bit free-running pwm_cnt (reset 0) increments every clk.
//   - speaker = sq & ((volume==3) | (pwm_cnt < volume)). volume 0 mutes the pin.
//   - busy and timing are unaffected.
// - TONE_VOLUME_EN undefined: no volume port; speaker = sq.
// TESTING
// - Bench parameters: CLK_HZ=100_000, NOTE_MS=10, so HALF=50_000 and NOTE_CYC=1000.
// - 1-clk playSound, freq=440, enable=1
//   -> busy rises 1 clk later and stays high 1000 clks.
//   -> speaker toggles exactly 8 times, then holds 0.
// - Same with freq=311 -> 6 toggles; freq=262 -> 5 toggles; busy 1000 clks each.
// - playSound held 3000 clks, freq=440
//   -> busy high 3000+1000-1 clks (retrigger restarts the timer each clk).
//   -> toggles = floor(3999*440/50000) = 35; no phase reset observed.
// - freq=0 with playSound=1, or enable=0 with freq=440 -> busy and speaker stay 0.
// - enable dropped 200 clks into a note -> busy=0 and speaker=0 next clk; nRst pulse mid-note -> same, immediately.
// - TONE_VOLUME_EN, volume=0 -> speaker stuck 0, busy still 1000 clks.
// - TONE_VOLUME_EN, volume=2 -> speaker high at most 2 of every 4 clks while sq=1.

Source files
------------

// File: rtl/tone_generator.sv
// =============================================================================
// tone_generator
// -----------------------------------------------------------------------------
// Sink side of the sound request interface. Each accepted request
// (enable & playSound & freq != 0) starts or retriggers a note: a square wave
// on the speaker pin at freq Hz, generated by a fractional phase accumulator
// (no divider), for NOTE_MS milliseconds after the last accepted request.
//
// Optional feature (compile-time macro TONE_VOLUME_EN):
//   Adds a 2-bit volume input. A free-running 2-bit PWM counter gates the
//   square wave: speaker = sq & ((volume == 3) | (pwm_cnt < volume)).
//   Volume 0 mutes the pin; busy and note timing are unaffected.
//   Without the macro there is no volume port and speaker = sq.
//
// Parameters
//   CLK_HZ   system clock frequency, Hz
//   NOTE_MS  note length after the last accepted request, ms
//   ACC_W    accumulator width; must hold CLK_HZ/2 + 511
//
// Ports
//   clk        in   1  system clock
//   nRst       in   1  asynchronous active-low reset
//   enable     in   1  sound mode ON (1) / OFF (0)
//   playSound  in   1  request strobe or level, sampled every clk
//   freq       in   9  requested tone in Hz; 0 = no tone
//   speaker    out  1  square-wave drive, registered
//   busy       out  1  high while a note is playing, registered
//   volume     in   2  output level, 0 = mute (TONE_VOLUME_EN only)
// =============================================================================
module tone_generator #(
    parameter int CLK_HZ  = 10_000_000,
    parameter int NOTE_MS = 100,
    parameter int ACC_W   = 24
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       enable,
    input  logic       playSound,
    input  logic [8:0] freq,
    output logic       speaker,
    output logic       busy
`ifdef TONE_VOLUME_EN
    ,
    input  logic [1:0] volume
`endif
);

    // -------------------------------------------------------------------------
    // Derived constants
    // -------------------------------------------------------------------------
    // One full output period spans 2*HALF accumulator units, so stepping by
    // f_lat per clk and toggling on every HALF crossing yields f_lat Hz exactly.
    localparam int HALF     = CLK_HZ / 2;
    localparam int NOTE_CYC = NOTE_MS * (CLK_HZ / 1000);
    localparam int DUR_W    = (NOTE_CYC > 1) ? $clog2(NOTE_CYC) : 1;

    localparam logic [ACC_W:0]   HALF_EXT = (ACC_W + 1)'(HALF);
    localparam logic [DUR_W-1:0] DUR_LAST = DUR_W'(NOTE_CYC - 1);

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t             state_q,   state_d;
    logic [ACC_W-1:0]   acc_q,     acc_d;
    logic [DUR_W-1:0]   dur_cnt_q, dur_cnt_d;
    logic [8:0]         f_lat_q,   f_lat_d;
    logic               sq_q,      sq_d;

    logic               accept;
    logic [ACC_W:0]     acc_sum;
    logic               acc_wrap;

    assign accept = enable & playSound & (freq != 9'd0);

    // One extra bit so acc + f_lat can never wrap before the compare.
    assign acc_sum  = {1'b0, acc_q} + (ACC_W + 1)'(f_lat_q);
    assign acc_wrap = (acc_sum >= HALF_EXT);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path can
        // leave it unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        acc_d     = acc_q;
        dur_cnt_d = dur_cnt_q;
        f_lat_d   = f_lat_q;
        sq_d      = sq_q;

        if (!enable) begin
            // Sound mode off: drop any note at once; requests are not queued.
            state_d   = IDLE;
            acc_d     = '0;
            dur_cnt_d = '0;
            sq_d      = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_d   = PLAY;
                        f_lat_d   = freq;
                        acc_d     = '0;
                        dur_cnt_d = '0;
                        sq_d      = 1'b0;
                    end
                end

                PLAY: begin
                    // Phase advance uses the currently latched frequency; a
                    // retrigger only changes the step from the next clk on.
                    if (acc_wrap) begin
                        acc_d = ACC_W'(acc_sum - HALF_EXT);
                        sq_d  = ~sq_q;
                    end else begin
                        acc_d = ACC_W'(acc_sum);
                    end

                    if (accept) begin
                        // Retrigger wins over terminal count. Phase (acc, sq)
                        // is kept so a sustained note stays continuous.
                        dur_cnt_d = '0;
                        f_lat_d   = freq;
                    end else if (dur_cnt_q == DUR_LAST) begin
                        state_d   = IDLE;
                        acc_d     = '0;
                        dur_cnt_d = '0;
                        sq_d      = 1'b0;
                    end else begin
                        dur_cnt_d = dur_cnt_q + DUR_W'(1);
                    end
                end

                default: begin
                    state_d   = IDLE;
                    acc_d     = '0;
                    dur_cnt_d = '0;
                    sq_d      = 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            dur_cnt_q <= '0;
            f_lat_q   <= '0;
            sq_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the
            // pre-edge values, independent of statement order.
            state_q   <= state_d;
            acc_q     <= acc_d;
            dur_cnt_q <= dur_cnt_d;
            f_lat_q   <= f_lat_d;
            sq_q      <= sq_d;
        end
    end

    assign busy = (state_q == PLAY);

    // -------------------------------------------------------------------------
    // Output stage
    // -------------------------------------------------------------------------
`ifdef TONE_VOLUME_EN
    logic [1:0] pwm_cnt_q, pwm_cnt_d;
    logic       vol_gate;
    logic       speaker_q, speaker_d;

    assign pwm_cnt_d = pwm_cnt_q + 2'd1;

    // The gate is evaluated against the PWM count that will be current when
    // the registered speaker value is visible, so the pin obeys
    // speaker = sq & ((volume == 3) | (pwm_cnt < volume)) cycle by cycle.
    assign vol_gate  = (volume == 2'd3) | (pwm_cnt_d < volume);
    assign speaker_d = sq_d & vol_gate;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            pwm_cnt_q <= 2'd0;
            speaker_q <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            speaker_q <= speaker_d;
        end
    end

    assign speaker = speaker_q;
`else
    assign speaker = sq_q;
`endif

endmodule

// File: tb/tb_tone_generator.sv
// =============================================================================
// tb_tone_generator
// -----------------------------------------------------------------------------
// Self-checking bench for tone_generator with CLK_HZ=100_000, NOTE_MS=10
// (HALF = 50_000, NOTE_CYC = 1000). Expected values come from closed-form
// rules: a note started by L consecutive accepted clks is busy for
// L + NOTE_CYC - 1 clks, and k clks after busy rises the square wave has
// toggled floor(k*f/HALF) times.
// Inputs change right after the falling edge; outputs are sampled there too.
// =============================================================================
module tb_tone_generator;

    localparam int CLK_HZ   = 100_000;
    localparam int NOTE_MS  = 10;
    localparam int HALF     = CLK_HZ / 2;
    localparam int NOTE_CYC = NOTE_MS * (CLK_HZ / 1000);

    logic       clk = 1'b0;
    logic       nRst = 1'b0;
    logic       enable = 1'b0;
    logic       playSound = 1'b0;
    logic [8:0] freq = '0;
    logic       speaker;
    logic       busy;
`ifdef TONE_VOLUME_EN
    logic [1:0] volume = 2'd3;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tone_generator #(
        .CLK_HZ (CLK_HZ),
        .NOTE_MS(NOTE_MS),
        .ACC_W  (24)
    ) dut (
        .clk      (clk),
        .nRst     (nRst),
        .enable   (enable),
        .playSound(playSound),
        .freq     (freq),
        .speaker  (speaker),
        .busy     (busy)
`ifdef TONE_VOLUME_EN
        ,
        .volume   (volume)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle_cycles(input int n);
        playSound = 1'b0;
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Plays one note: playSound held for len clks at frequency f with the
    // given enable, then watches until well past the expected end.
    // Reports busy length and toggle count seen; checks latency, waveform
    // phase and the idle return against the closed-form model.
    task automatic run_note(input string tag, input int f, input int len, input bit en,
                            output int busy_len, output int toggles);
        bit   valid;
        int   wave_err;
        int   exp_len;
        bit   prev_busy;
        bit   prev_spk;
        bit   end_ok;
        valid     = en && (f != 0);
        exp_len   = valid ? len + NOTE_CYC - 1 : 0;
        busy_len  = 0;
        toggles   = 0;
        wave_err  = 0;
        prev_busy = 1'b0;
        prev_spk  = 1'b0;
        end_ok    = 1'b1;
        freq      = 9'(f);
        enable    = en;
        playSound = 1'b1;
        for (int c = 0; c < len + NOTE_CYC + 20; c++) begin
            @(negedge clk);
            if (c == len - 1) playSound = 1'b0;
            if (c == 0) check({tag, "_latency"}, busy, valid);
            if (busy) begin
                // busy_len PLAY clks have elapsed since busy rose.
                if (speaker !== 1'(((longint'(busy_len) * f) / HALF) % 2)) wave_err++;
                if (prev_busy && speaker != prev_spk) toggles++;
                busy_len++;
            end else if (speaker !== 1'b0) begin
                end_ok = 1'b0;
            end
            prev_busy = busy;
            prev_spk  = speaker;
        end
        check({tag, "_busy_len"}, busy_len, exp_len);
        check({tag, "_toggles"}, toggles, valid ? ((exp_len - 1) * f) / HALF : 0);
        check({tag, "_wave"}, wave_err, 0);
        check({tag, "_idle_spk"}, end_ok, 1);
        enable = 1'b1;
        idle_cycles(3);
    endtask

    initial begin
        int blen;
        int tog;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_spk", speaker, 0);
        nRst   = 1'b1;
        enable = 1'b1;
        idle_cycles(2);
        check("idle_busy", busy, 0);

        // Directed notes from the specification
        run_note("n440", 440, 1, 1'b1, blen, tog);
        check("n440_8tog", tog, 8);
        run_note("n311", 311, 1, 1'b1, blen, tog);
        check("n311_6tog", tog, 6);
        run_note("n262", 262, 1, 1'b1, blen, tog);
        check("n262_5tog", tog, 5);
        check("n262_len", blen, 1000);
        run_note("held", 440, 3000, 1'b1, blen, tog);
        check("held_len", blen, 3999);
        check("held_35tog", tog, 35);

        // Requests that must be ignored
        run_note("f0", 0, 5, 1'b1, blen, tog);
        run_note("en0", 440, 5, 1'b0, blen, tog);

        // Retrigger on the terminal-count clk: the note must continue.
        freq      = 9'd440;
        playSound = 1'b1;
        @(negedge clk);
        playSound = 1'b0;
        blen = 1;
        for (int c = 1; c < NOTE_CYC; c++) begin
            @(negedge clk);
            if (busy) blen++;
        end
        playSound = 1'b1;
        @(negedge clk);
        playSound = 1'b0;
        check("tc_retrig_busy", busy, 1);
        for (int c = 0; c < NOTE_CYC + 20; c++) begin
            if (busy) blen++;
            @(negedge clk);
        end
        check("tc_retrig_len", blen, 2 * NOTE_CYC);
        idle_cycles(3);

        // enable dropped 200 clks into a note
        freq      = 9'd440;
        playSound = 1'b1;
        @(negedge clk);
        playSound = 1'b0;
        repeat (200) @(negedge clk);
        check("en_drop_pre_spk", speaker, 1);   // floor(200*440/50000) = 1
        enable = 1'b0;
        @(negedge clk);
        check("en_drop_busy", busy, 0);
        check("en_drop_spk", speaker, 0);
        enable = 1'b1;
        idle_cycles(3);

        // Asynchronous reset mid-note
        freq      = 9'd440;
        playSound = 1'b1;
        @(negedge clk);
        playSound = 1'b0;
        repeat (150) @(negedge clk);
        check("rst_mid_pre_busy", busy, 1);
        check("rst_mid_pre_spk", speaker, 1);   // floor(150*440/50000) = 1
        #2 nRst = 1'b0;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_spk", speaker, 0);
        @(negedge clk);
        nRst = 1'b1;
        idle_cycles(3);

        // Randomized notes
        for (int i = 0; i < 12; i++) begin
            int rf;
            int rl;
            bit re;
            rf = ($urandom_range(9, 0) == 0) ? 0 : int'($urandom_range(511, 1));
            rl = int'($urandom_range(40, 1));
            re = ($urandom_range(7, 0) != 0);
            run_note($sformatf("rnd%0d", i), rf, rl, re, blen, tog);
        end

`ifdef TONE_VOLUME_EN
        begin
            int hi_cnt;
            int win_err;
            bit win [4];
            volume = 2'd0;
            freq      = 9'd440;
            playSound = 1'b1;
            @(negedge clk);
            playSound = 1'b0;
            blen = 0;
            hi_cnt = 0;
            for (int c = 0; c < NOTE_CYC + 20; c++) begin
                if (busy) blen++;
                if (speaker) hi_cnt++;
                @(negedge clk);
            end
            check("vol0_busy_len", blen, NOTE_CYC);
            check("vol0_spk_high", hi_cnt, 0);

            volume = 2'd2;
            freq      = 9'd440;
            playSound = 1'b1;
            @(negedge clk);
            playSound = 1'b0;
            win_err = 0;
            hi_cnt  = 0;
            for (int c = 0; c < NOTE_CYC + 20; c++) begin
                win[c % 4] = speaker;
                if (speaker) hi_cnt++;
                if (c >= 3 && (int'(win[0]) + int'(win[1]) + int'(win[2]) + int'(win[3])) > 2)
                    win_err++;
                @(negedge clk);
            end
            check("vol2_duty", win_err, 0);
            check("vol2_some_high", hi_cnt > 0, 1);
            volume = 2'd3;
            idle_cycles(3);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends on its own.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
